// File: rtl/pcap_rd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pcap_rd_pkg: shared types and constants for the packet read control. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pcap_rd_pkg;

  typedef enum logic [1:0] {
    RD_IDLE      = 2'd0,
    RD_ISSUE     = 2'd1,
    RD_WAIT_DATA = 2'd2
  } rd_state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int DEF_MAX_BURST  = 8;

endpackage
`default_nettype wire

// File: rtl/pcap_rd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pcap_rd_ctrl: copies one packet from Avalon-MM memory into the       |
// | capture FIFO using bursts with at most one burst outstanding.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pcap_rd_ctrl
  import pcap_rd_pkg::*;
#(
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rd_ctrl,
  input  logic               almost_full,
  input  logic [31:0]        control,
  input  logic [ADDR_W-1:0]  pkt_begin,
  input  logic [ADDR_W-1:0]  pkt_end,
  output logic [DATA_W-1:0]  fifo_in,
  output logic               wr_to_fifo,
  output logic               rd_ctrl_rdy,
  output logic [ADDR_W-1:0]  address,
  output logic               read,
  output logic [BURST_W-1:0] burstcount,
  input  logic [DATA_W-1:0]  readdata,
  input  logic               readdatavalid,
  input  logic               waitrequest
);

  rd_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  address_q, address_d;
  logic [ADDR_W-1:0]  remaining_q, remaining_d;
  logic [BURST_W-1:0] burstcount_q, burstcount_d;
  logic [BURST_W-1:0] beat_cnt_q, beat_cnt_d;
  logic               read_q, read_d;
  logic [DATA_W-1:0]  fifo_in_q, fifo_in_d;
  logic               wr_q, wr_d;
  logic [31:0]        control_q, control_d;

  logic [ADDR_W-1:0]  w_aligned;
  logic [ADDR_W:0]    w_span;
  logic [ADDR_W-1:0]  w_words;
  logic               w_nonempty;
  logic [ADDR_W-1:0]  w_rem_after;
  logic               w_last_beat;

  function automatic logic [BURST_W-1:0] clip_burst(input logic [ADDR_W-1:0] rem);
    if (rem >= ADDR_W'(MAX_BURST)) begin
      return BURST_W'(MAX_BURST);
    end
    return BURST_W'(rem);
  endfunction

  // One extra bit on the span keeps the round-up from wrapping near the top of memory.
  assign w_aligned   = {pkt_begin[ADDR_W-1:2], 2'b00};
  assign w_span      = {1'b0, pkt_end} - {1'b0, w_aligned} + (ADDR_W+1)'(3);
  assign w_words     = ADDR_W'(w_span >> 2);
  assign w_nonempty  = pkt_end > pkt_begin;
  assign w_rem_after = remaining_q - ADDR_W'(burstcount_q);
  assign w_last_beat = (beat_cnt_q == burstcount_q - 1'b1);

  always_comb begin
    state_d      = state_q;
    address_d    = address_q;
    remaining_d  = remaining_q;
    burstcount_d = burstcount_q;
    beat_cnt_d   = beat_cnt_q;
    read_d       = read_q;
    control_d    = control_q;
    wr_d         = (state_q == RD_WAIT_DATA) && readdatavalid;
    fifo_in_d    = wr_d ? readdata : fifo_in_q;

    case (state_q)
      RD_IDLE: begin
        if (rd_ctrl && w_nonempty) begin
          control_d    = control;
          address_d    = w_aligned;
          remaining_d  = w_words;
          burstcount_d = clip_burst(w_words);
          beat_cnt_d   = '0;
          read_d       = !almost_full;
          state_d      = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        if (read_q) begin
          if (!waitrequest) begin
            read_d     = 1'b0;
            beat_cnt_d = '0;
            state_d    = RD_WAIT_DATA;
          end
        end else if (!almost_full) begin
          read_d = 1'b1;
        end
      end
      RD_WAIT_DATA: begin
        if (readdatavalid) begin
          if (w_last_beat) begin
            remaining_d  = w_rem_after;
            address_d    = address_q + ADDR_W'(burstcount_q) * ADDR_W'(BYTES_PER_WORD);
            burstcount_d = clip_burst(w_rem_after);
            beat_cnt_d   = '0;
            if (w_rem_after != '0) begin
              read_d  = !almost_full;
              state_d = RD_ISSUE;
            end else begin
              state_d = RD_IDLE;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = RD_IDLE;
        read_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RD_IDLE;
      address_q    <= '0;
      remaining_q  <= '0;
      burstcount_q <= '0;
      beat_cnt_q   <= '0;
      read_q       <= 1'b0;
      fifo_in_q    <= '0;
      wr_q         <= 1'b0;
      control_q    <= '0;
    end else begin
      state_q      <= state_d;
      address_q    <= address_d;
      remaining_q  <= remaining_d;
      burstcount_q <= burstcount_d;
      beat_cnt_q   <= beat_cnt_d;
      read_q       <= read_d;
      fifo_in_q    <= fifo_in_d;
      wr_q         <= wr_d;
      control_q    <= control_d;
    end
  end

  // The control word is held for future use and has no effect today.
  logic unused_control;
  assign unused_control = ^control_q;

  assign rd_ctrl_rdy = (state_q == RD_IDLE);
  assign address     = address_q;
  assign burstcount  = burstcount_q;
  assign read        = read_q;
  assign fifo_in     = fifo_in_q;
  assign wr_to_fifo  = wr_q;

endmodule
`default_nettype wire

// File: tb/tb_pcap_rd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pcap_rd_ctrl: directed self-checking bench for pcap_rd_ctrl.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pcap_rd_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_ctrl;
  logic        almost_full;
  logic [31:0] control;
  logic [31:0] pkt_begin;
  logic [31:0] pkt_end;
  logic [31:0] fifo_in;
  logic        wr_to_fifo;
  logic        rd_ctrl_rdy;
  logic [31:0] address;
  logic        read;
  logic [15:0] burstcount;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;

  int errors = 0;
  int checks = 0;
  logic [31:0] wq[$];

  pcap_rd_ctrl dut (
    .clk(clk), .reset(reset), .rd_ctrl(rd_ctrl), .almost_full(almost_full),
    .control(control), .pkt_begin(pkt_begin), .pkt_end(pkt_end),
    .fifo_in(fifo_in), .wr_to_fifo(wr_to_fifo), .rd_ctrl_rdy(rd_ctrl_rdy),
    .address(address), .read(read), .burstcount(burstcount),
    .readdata(readdata), .readdatavalid(readdatavalid), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_to_fifo === 1'b1) wq.push_back(fifo_in);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] b, input logic [31:0] e);
    pkt_begin = b;
    pkt_end   = e;
    control   = 32'hC0DE_0000 ^ e;
    rd_ctrl   = 1'b1;
    tick();
    rd_ctrl   = 1'b0;
  endtask

  // Plays the Avalon slave for one burst, returning 10,11,... as data.
  task automatic serve(input logic [31:0] exp_addr, input logic [15:0] exp_bc,
                       input int wait_cyc, input int gap_at, input int gap_len,
                       input logic af_during);
    int n;
    n = 0;
    while (read !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (read !== 1'b1) begin
      errors++;
      $display("FAIL read_timeout: read=%b required 1", read);
      return;
    end
    checks++;
    if (address !== exp_addr) begin
      errors++;
      $display("FAIL burst_addr: got %0d required %0d", address, exp_addr);
    end
    checks++;
    if (burstcount !== exp_bc) begin
      errors++;
      $display("FAIL burst_count: got %0d required %0d", burstcount, exp_bc);
    end
    waitrequest = 1'b1;
    for (int i = 0; i < wait_cyc; i++) begin
      tick();
      checks++;
      if (read !== 1'b1 || address !== exp_addr || burstcount !== exp_bc) begin
        errors++;
        $display("FAIL wait_hold: read=%b addr=%0d bc=%0d required 1/%0d/%0d",
                 read, address, burstcount, exp_addr, exp_bc);
      end
    end
    waitrequest = 1'b0;
    tick();
    checks++;
    if (read !== 1'b0) begin
      errors++;
      $display("FAIL read_deassert: read=%b required 0", read);
    end
    almost_full = af_during;
    for (int i = 0; i < int'(exp_bc); i++) begin
      if (i == gap_at) begin
        readdatavalid = 1'b0;
        repeat (gap_len) tick();
      end
      readdatavalid = 1'b1;
      readdata      = 32'(10 + i);
      tick();
    end
    readdatavalid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (read !== 1'b0 || address !== 32'd0 || burstcount !== 16'd0 ||
        wr_to_fifo !== 1'b0 || fifo_in !== 32'd0 || rd_ctrl_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: read=%b addr=%0d bc=%0d wr=%b din=%0d rdy=%b required 0/0/0/0/0/1",
               read, address, burstcount, wr_to_fifo, fifo_in, rd_ctrl_rdy);
    end
  endtask

  task automatic test_multi_burst();
    bit bad;
    logic [31:0] exp;
    wq.delete();
    start(32'd0, 32'd66);
    checks++;
    if (rd_ctrl_rdy !== 1'b0 || read !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: rdy=%b read=%b required 0/1", rd_ctrl_rdy, read);
    end
    serve(32'd0, 16'd8, 0, -1, 0, 1'b0);
    checks++;
    if (read !== 1'b1 || rd_ctrl_rdy !== 1'b0) begin
      errors++;
      $display("FAIL next_burst_latency: read=%b rdy=%b required 1/0", read, rd_ctrl_rdy);
    end
    serve(32'd32, 16'd8, 0, -1, 0, 1'b0);
    serve(32'd64, 16'd1, 0, -1, 0, 1'b0);
    checks++;
    if (rd_ctrl_rdy !== 1'b1 || wr_to_fifo !== 1'b1 || fifo_in !== 32'd10) begin
      errors++;
      $display("FAIL final_beat: rdy=%b wr=%b din=%0d required 1/1/10",
               rd_ctrl_rdy, wr_to_fifo, fifo_in);
    end
    tick();
    checks++;
    bad = (wq.size() != 17);
    for (int i = 0; i < wq.size() && i < 17; i++) begin
      exp = (i < 16) ? 32'(10 + (i % 8)) : 32'd10;
      if (wq[i] !== exp) bad = 1'b1;
    end
    if (bad) begin
      errors++;
      $display("FAIL multi_fifo_data: got %0d writes required 17 (10..17,10..17,10)", wq.size());
    end
  endtask

  task automatic test_empty();
    wq.delete();
    start(32'd0, 32'd0);
    checks++;
    if (rd_ctrl_rdy !== 1'b1 || read !== 1'b0) begin
      errors++;
      $display("FAIL empty_desc: rdy=%b read=%b required 1/0", rd_ctrl_rdy, read);
    end
    start(32'd12, 32'd8);
    repeat (3) tick();
    checks++;
    if (rd_ctrl_rdy !== 1'b1 || read !== 1'b0 || wq.size() != 0) begin
      errors++;
      $display("FAIL reversed_desc: rdy=%b read=%b writes=%0d required 1/0/0",
               rd_ctrl_rdy, read, wq.size());
    end
  endtask

  task automatic test_waitrequest();
    bit bad;
    wq.delete();
    start(32'd0, 32'd32);
    serve(32'd0, 16'd8, 3, -1, 0, 1'b0);
    checks++;
    if (rd_ctrl_rdy !== 1'b1) begin
      errors++;
      $display("FAIL wait_done_rdy: rdy=%b required 1", rd_ctrl_rdy);
    end
    tick();
    checks++;
    bad = (wq.size() != 8);
    for (int i = 0; i < wq.size() && i < 8; i++) if (wq[i] !== 32'(10 + i)) bad = 1'b1;
    if (bad) begin
      errors++;
      $display("FAIL wait_fifo_data: got %0d writes required 8 (10..17)", wq.size());
    end
  endtask

  task automatic test_gap();
    bit bad;
    wq.delete();
    start(32'd0, 32'd32);
    serve(32'd0, 16'd8, 0, 4, 2, 1'b0);
    tick();
    checks++;
    bad = (wq.size() != 8);
    for (int i = 0; i < wq.size() && i < 8; i++) if (wq[i] !== 32'(10 + i)) bad = 1'b1;
    if (bad) begin
      errors++;
      $display("FAIL gap_fifo_data: got %0d writes required 8 (10..17)", wq.size());
    end
  endtask

  task automatic test_unaligned();
    bit bad;
    wq.delete();
    start(32'd5, 32'd13);
    serve(32'd4, 16'd3, 0, -1, 0, 1'b0);
    tick();
    checks++;
    bad = (wq.size() != 3);
    for (int i = 0; i < wq.size() && i < 3; i++) if (wq[i] !== 32'(10 + i)) bad = 1'b1;
    if (bad) begin
      errors++;
      $display("FAIL unaligned_data: got %0d writes required 3 (10..12)", wq.size());
    end
  endtask

  task automatic test_almost_full();
    wq.delete();
    start(32'd0, 32'd64);
    serve(32'd0, 16'd8, 0, -1, 0, 1'b1);
    repeat (3) tick();
    checks++;
    if (read !== 1'b0 || rd_ctrl_rdy !== 1'b0) begin
      errors++;
      $display("FAIL af_block: read=%b rdy=%b required 0/0", read, rd_ctrl_rdy);
    end
    checks++;
    if (wq.size() != 8) begin
      errors++;
      $display("FAIL af_first_burst: got %0d writes required 8", wq.size());
    end
    almost_full = 1'b0;
    tick();
    checks++;
    if (read !== 1'b1) begin
      errors++;
      $display("FAIL af_release: read=%b required 1", read);
    end
    serve(32'd32, 16'd8, 0, -1, 0, 1'b0);
    tick();
    checks++;
    if (wq.size() != 16 || rd_ctrl_rdy !== 1'b1) begin
      errors++;
      $display("FAIL af_total: writes=%0d rdy=%b required 16/1", wq.size(), rd_ctrl_rdy);
    end
  endtask

  task automatic test_reset_mid();
    start(32'd0, 32'd32);
    tick();
    for (int i = 0; i < 3; i++) begin
      readdatavalid = 1'b1;
      readdata      = 32'(50 + i);
      tick();
    end
    reset = 1'b0;
    #1;
    checks++;
    if (read !== 1'b0 || address !== 32'd0 || burstcount !== 16'd0 ||
        wr_to_fifo !== 1'b0 || fifo_in !== 32'd0 || rd_ctrl_rdy !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: read=%b addr=%0d bc=%0d wr=%b din=%0d rdy=%b required 0/0/0/0/0/1",
               read, address, burstcount, wr_to_fifo, fifo_in, rd_ctrl_rdy);
    end
    repeat (2) tick();
    reset = 1'b1;
    wq.delete();
    repeat (3) tick();
    readdatavalid = 1'b0;
    tick();
    checks++;
    if (wq.size() != 0 || read !== 1'b0) begin
      errors++;
      $display("FAIL aborted_beats: writes=%0d read=%b required 0/0", wq.size(), read);
    end
    start(32'd0, 32'd8);
    serve(32'd0, 16'd2, 0, -1, 0, 1'b0);
    tick();
    checks++;
    if (wq.size() != 2 || rd_ctrl_rdy !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_xfer: writes=%0d rdy=%b required 2/1", wq.size(), rd_ctrl_rdy);
    end else begin
      checks++;
      if (wq[0] !== 32'd10 || wq[1] !== 32'd11) begin
        errors++;
        $display("FAIL post_reset_data: got %0d,%0d required 10,11", wq[0], wq[1]);
      end
    end
  endtask

  initial begin
    reset         = 1'b0;
    rd_ctrl       = 1'b0;
    almost_full   = 1'b0;
    control       = '0;
    pkt_begin     = '0;
    pkt_end       = '0;
    readdata      = '0;
    readdatavalid = 1'b0;
    waitrequest   = 1'b0;
    repeat (2) tick();
    test_reset();
    reset = 1'b1;
    tick();
    test_multi_burst();
    test_empty();
    test_waitrequest();
    test_gap();
    test_unaligned();
    test_almost_full();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
